// File: rtl/pipe_ctrl_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_ctrl_fsm_pkg                                              |
// | Brief   : Y86-64 encodings and control-FSM state type for pipe_ctrl_fsm  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package pipe_ctrl_fsm_pkg;

    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_POPQ   = 4'hB;
    localparam logic [3:0] c_R_NONE   = 4'hF;
    localparam logic [3:0] c_S_AOK    = 4'h1;

    typedef enum logic [1:0] {
        CTL_RUN      = 2'd0,
        CTL_RET_WAIT = 2'd1,
        CTL_HALTED   = 2'd2
    } ctl_state_e;

    // Instructions whose result only exists after the memory stage.
    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == c_I_MRMOVQ) || (icode == c_I_POPQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_fsm_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_hazard_detect                                             |
// | Brief   : Combinational load-use / mispredict / ret / exception terms    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pipe_hazard_detect
    import pipe_ctrl_fsm_pkg::*;
(
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_Cnd_i,
    input  logic [3:0] m_stat_i,
    input  logic [3:0] W_stat_i,
    output logic       load_use_o,
    output logic       mispred_o,
    output logic       ret_d_o,
    output logic       exc_m_o,
    output logic       exc_w_o
);

    assign load_use_o = is_mem_load(E_icode_i) && (E_dstM_i != c_R_NONE) &&
                        ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign mispred_o  = (E_icode_i == c_I_JXX) && !e_Cnd_i;
    assign ret_d_o    = (D_icode_i == c_I_RET);
    assign exc_m_o    = (m_stat_i != c_S_AOK);
    assign exc_w_o    = (W_stat_i != c_S_AOK);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_ctrl_fsm                                                  |
// | Brief   : Y86-64 stall/bubble sequencer with ret drain and sticky halt.  |
// |           Optional perf counters enabled by PIPE_PERF_CNT_EN.            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pipe_ctrl_fsm
    import pipe_ctrl_fsm_pkg::*;
#(
    parameter int RET_DRAIN = 2,
    parameter int CNT_W     = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_Cnd_i,
    input  logic [3:0] m_stat_i,
    input  logic [3:0] W_stat_i,
    output logic       F_stall_o,
    output logic       D_stall_o,
    output logic       D_bubble_o,
    output logic       E_bubble_o,
    output logic       M_bubble_o,
    output logic       W_stall_o,
    output logic [1:0] ctrl_state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
`endif
);

    localparam int c_RCNT_W = $clog2(RET_DRAIN + 1);

    ctl_state_e          state_q, state_d;
    logic [c_RCNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic w_load_use, w_mispred, w_ret_d, w_exc_m, w_exc_w;
    logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall;

    pipe_hazard_detect u_hazard (
        .D_icode_i  (D_icode_i),
        .d_srcA_i   (d_srcA_i),
        .d_srcB_i   (d_srcB_i),
        .E_icode_i  (E_icode_i),
        .E_dstM_i   (E_dstM_i),
        .e_Cnd_i    (e_Cnd_i),
        .m_stat_i   (m_stat_i),
        .W_stat_i   (W_stat_i),
        .load_use_o (w_load_use),
        .mispred_o  (w_mispred),
        .ret_d_o    (w_ret_d),
        .exc_m_o    (w_exc_m),
        .exc_w_o    (w_exc_w)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CTL_RUN;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_cnt_d  = ret_cnt_q;
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_m_bubble = 1'b0;
        w_w_stall  = 1'b0;
        case (state_q)
            CTL_RUN: begin
                if (w_exc_w) begin
                    {w_f_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall} = '1;
                    state_d = CTL_HALTED;
                end else begin
                    w_m_bubble = w_exc_m;
                    // Stall wins over bubble in D, so a waiting ret is kept, not squashed.
                    if (w_load_use) begin
                        w_f_stall  = 1'b1;
                        w_d_stall  = 1'b1;
                        w_e_bubble = 1'b1;
                    end else if (w_mispred) begin
                        w_d_bubble = 1'b1;
                        w_e_bubble = 1'b1;
                    end else if (w_ret_d) begin
                        w_f_stall  = 1'b1;
                        w_d_bubble = 1'b1;
                        state_d    = CTL_RET_WAIT;
                        ret_cnt_d  = c_RCNT_W'(RET_DRAIN);
                    end
                end
            end
            CTL_RET_WAIT: begin
                if (w_exc_w) begin
                    {w_f_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall} = '1;
                    state_d   = CTL_HALTED;
                    ret_cnt_d = '0;
                end else begin
                    w_f_stall  = 1'b1;
                    w_d_bubble = 1'b1;
                    w_m_bubble = w_exc_m;
                    ret_cnt_d  = ret_cnt_q - c_RCNT_W'(1);
                    if (ret_cnt_q == c_RCNT_W'(1)) begin
                        state_d = CTL_RUN;
                    end
                end
            end
            CTL_HALTED: begin
                {w_f_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall} = '1;
            end
            default: begin
                state_d   = CTL_RUN;
                ret_cnt_d = '0;
            end
        endcase
    end

    // Reset drives the controls directly so the pipeline is held from the very first instant.
    assign F_stall_o    = rst_i | w_f_stall;
    assign D_stall_o    = !rst_i & w_d_stall;
    assign D_bubble_o   = rst_i | w_d_bubble;
    assign E_bubble_o   = rst_i | w_e_bubble;
    assign M_bubble_o   = rst_i | w_m_bubble;
    assign W_stall_o    = !rst_i & w_w_stall;
    assign ctrl_state_o = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic w_stall_inc, w_bubble_inc, w_mispred_inc;
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, mispred_cnt_q;

    always_comb begin
        w_stall_inc   = 1'b0;
        w_bubble_inc  = 1'b0;
        w_mispred_inc = 1'b0;
        if (state_q == CTL_RUN && !w_exc_w) begin
            w_stall_inc   = w_load_use || (!w_mispred && w_ret_d);
            w_mispred_inc = !w_load_use && w_mispred;
        end else if (state_q == CTL_RET_WAIT && !w_exc_w) begin
            w_stall_inc = 1'b1;
        end
        w_bubble_inc = (state_q != CTL_HALTED) && w_e_bubble;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q   <= '0;
            bubble_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_q   + CNT_W'(w_stall_inc);
            bubble_cnt_q  <= bubble_cnt_q  + CNT_W'(w_bubble_inc);
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(w_mispred_inc);
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign bubble_cnt_o  = bubble_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    if (CNT_W > 0) begin : g_no_perf_cnt
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipe_ctrl_fsm                                               |
// | Brief   : Directed self-checking bench for pipe_ctrl_fsm                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pipe_ctrl_fsm;

    localparam logic [3:0] c_NOP = 4'h1, c_RRMOV = 4'h2, c_MRMOV = 4'h5, c_JXX = 4'h7;
    localparam logic [3:0] c_RET = 4'h9, c_POP = 4'hB;
    localparam logic [3:0] c_RAX = 4'h0, c_RSP = 4'h4, c_NREG = 4'hF;
    localparam logic [3:0] c_AOK = 4'h1, c_ADR = 4'h3, c_INS = 4'h4;

    // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    localparam logic [5:0] c_IDLE = 6'b000000, c_RST = 6'b101110, c_LU = 6'b110100;
    localparam logic [5:0] c_MP   = 6'b001100, c_RT  = 6'b101000, c_HLT = 6'b101111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] D_icode = c_NOP, d_srcA = c_NREG, d_srcB = c_NREG;
    logic [3:0] E_icode = c_NOP, E_dstM = c_NREG, m_stat = c_AOK, W_stat = c_AOK;
    logic       e_Cnd = 1'b1;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt, mispred_cnt;
`endif
    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_fsm #(.RET_DRAIN(2), .CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .D_icode_i    (D_icode),
        .d_srcA_i     (d_srcA),
        .d_srcB_i     (d_srcB),
        .E_icode_i    (E_icode),
        .E_dstM_i     (E_dstM),
        .e_Cnd_i      (e_Cnd),
        .m_stat_i     (m_stat),
        .W_stat_i     (W_stat),
        .F_stall_o    (F_stall),
        .D_stall_o    (D_stall),
        .D_bubble_o   (D_bubble),
        .E_bubble_o   (E_bubble),
        .M_bubble_o   (M_bubble),
        .W_stall_o    (W_stall),
        .ctrl_state_o (ctrl_state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .bubble_cnt_o  (bubble_cnt),
        .mispred_cnt_o (mispred_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miscmp++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] ei, input logic [3:0] ed, input logic cnd,
                         input logic [3:0] ms, input logic [3:0] ws);
        @(negedge clk);
        D_icode = di; d_srcA = sa; d_srcB = sb;
        E_icode = ei; E_dstM = ed; e_Cnd = cnd;
        m_stat  = ms; W_stat = ws;
    endtask

    task automatic idle();
        drive(c_NOP, c_NREG, c_NREG, c_NOP, c_NREG, 1'b1, c_AOK, c_AOK);
    endtask

    task automatic exp_ctl(input string tag, input logic [1:0] st, input logic [5:0] c);
        #1;
        chk(tag, {24'd0, ctrl_state, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall},
            {24'd0, st, c});
    endtask

    initial begin
        #3;
        exp_ctl("reset", 2'd0, c_RST);
        @(negedge clk); rst = 1'b0;
        idle();                                          exp_ctl("idle", 2'd0, c_IDLE);

        drive(c_RRMOV, c_RAX, c_NREG, c_MRMOV, c_RAX, 1'b1, c_AOK, c_AOK);
        exp_ctl("load_use", 2'd0, c_LU);
        idle();                                          exp_ctl("load_use_after", 2'd0, c_IDLE);
        drive(c_RRMOV, c_NREG, c_NREG, c_MRMOV, c_NREG, 1'b1, c_AOK, c_AOK);
        exp_ctl("no_lu_nreg", 2'd0, c_IDLE);
        drive(c_RRMOV, c_RAX, c_NREG, c_RRMOV, c_RAX, 1'b1, c_AOK, c_AOK);
        exp_ctl("no_lu_rrmov", 2'd0, c_IDLE);

        drive(c_RET, c_RSP, c_RSP, c_JXX, c_NREG, 1'b0, c_AOK, c_AOK);
        exp_ctl("mispred_ret", 2'd0, c_MP);
        idle();                                          exp_ctl("mispred_after", 2'd0, c_IDLE);

        drive(c_RET, c_RSP, c_RSP, c_NOP, c_NREG, 1'b1, c_AOK, c_AOK);
        exp_ctl("ret_d", 2'd0, c_RT);
        idle();                                          exp_ctl("ret_w1", 2'd1, c_RT);
        idle();                                          exp_ctl("ret_w2", 2'd1, c_RT);
        idle();                                          exp_ctl("ret_done", 2'd0, c_IDLE);

        drive(c_RET, c_RSP, c_RSP, c_POP, c_RSP, 1'b1, c_AOK, c_AOK);
        exp_ctl("lu_ret_stall", 2'd0, c_LU);
        drive(c_RET, c_RSP, c_RSP, c_NOP, c_NREG, 1'b1, c_AOK, c_AOK);
        exp_ctl("lu_ret_d", 2'd0, c_RT);
        idle();                                          exp_ctl("lu_ret_w1", 2'd1, c_RT);
        idle();                                          exp_ctl("lu_ret_w2", 2'd1, c_RT);
        idle();                                          exp_ctl("lu_ret_done", 2'd0, c_IDLE);

        drive(c_RRMOV, c_RAX, c_NREG, c_MRMOV, c_RAX, 1'b1, c_ADR, c_AOK);
        exp_ctl("exc_m_lu", 2'd0, 6'b110110);
        drive(c_NOP, c_NREG, c_NREG, c_NOP, c_NREG, 1'b1, c_ADR, c_AOK);
        exp_ctl("exc_m", 2'd0, 6'b000010);
        drive(c_NOP, c_NREG, c_NREG, c_NOP, c_NREG, 1'b1, c_AOK, c_ADR);
        exp_ctl("exc_w", 2'd0, c_HLT);
        idle();                                          exp_ctl("halted1", 2'd2, c_HLT);
        idle();                                          exp_ctl("halted2", 2'd2, c_HLT);
        #2 rst = 1'b1;
        exp_ctl("rst_halted", 2'd0, c_RST);
        @(negedge clk); rst = 1'b0;
        idle();                                          exp_ctl("post_halt", 2'd0, c_IDLE);

        drive(c_RET, c_RSP, c_RSP, c_NOP, c_NREG, 1'b1, c_AOK, c_AOK);
        exp_ctl("ret2_d", 2'd0, c_RT);
        drive(c_NOP, c_NREG, c_NREG, c_NOP, c_NREG, 1'b1, c_AOK, c_INS);
        exp_ctl("retw_exc_w", 2'd1, c_HLT);
        idle();                                          exp_ctl("retw_halted", 2'd2, c_HLT);
        #2 rst = 1'b1;
        #1;
        @(negedge clk); rst = 1'b0;

        drive(c_RET, c_RSP, c_RSP, c_NOP, c_NREG, 1'b1, c_AOK, c_AOK);
        exp_ctl("ret3_d", 2'd0, c_RT);
        idle();                                          exp_ctl("ret3_w1", 2'd1, c_RT);
        #2 rst = 1'b1;
        exp_ctl("rst_retwait", 2'd0, c_RST);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt_rst", stall_cnt, 32'd0);
        chk("bubble_cnt_rst", bubble_cnt, 32'd0);
        chk("mispred_cnt_rst", mispred_cnt, 32'd0);
`endif
        @(negedge clk); rst = 1'b0;
        idle();                                          exp_ctl("post_retwait", 2'd0, c_IDLE);
        idle();                                          exp_ctl("no_pending_ret", 2'd0, c_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
